// File: rtl/branch_predictor_controller.sv
// Branch predictor controller: owns a PHT of 2-bit saturating counters, answers
// fetch lookups, tracks in-flight predictions in a FIFO and retires them in order.
module branch_predictor_controller #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned DEPTH      = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lookup_valid,
    input  logic [INDEX_BITS-1:0]   lookup_index,
    output logic                    lookup_ready,
    output logic                    predict_valid,
    output logic                    predict,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    output logic                    mispredict,
    output logic                    resolve_error,
    output logic [$clog2(DEPTH):0]  inflight_count,
    output logic                    init_done
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             pht [ENTRIES];
    logic [INDEX_BITS-1:0]  init_ptr_q, init_ptr_d;
    logic [INDEX_BITS-1:0]  fifo_idx [DEPTH];
    logic                   fifo_pred [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   lookup_fire;
    logic                   pht_we;
    logic [INDEX_BITS-1:0]  pht_waddr;
    logic [1:0]             pht_wdata;
    logic [INDEX_BITS-1:0]  head_idx;
    logic                   head_pred;
    logic [1:0]             head_ctr;
    logic                   predict_valid_d, predict_d, mispredict_d, resolve_error_d;

    // Lookup is only accepted in RUN with FIFO space and no competing resolve.
    assign lookup_ready = !reset && (state_q == ST_RUN) &&
                          (count_q < CNT_W'(DEPTH)) && !resolve_valid;

    assign inflight_count = count_q;

    // Next-state, PHT access arbitration (resolve wins) and FIFO bookkeeping.
    always_comb begin
        state_d         = state_q;
        init_ptr_d      = init_ptr_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        lookup_fire     = 1'b0;
        pht_we          = 1'b0;
        pht_waddr       = init_ptr_q;
        pht_wdata       = INIT_STATE;
        predict_valid_d = 1'b0;
        predict_d       = 1'b0;
        mispredict_d    = 1'b0;
        resolve_error_d = 1'b0;
        head_idx        = fifo_idx[head_q];
        head_pred       = fifo_pred[head_q];
        head_ctr        = pht[head_idx];

        case (state_q)
            ST_INIT: begin
                pht_we     = 1'b1;
                init_ptr_d = init_ptr_q + INDEX_BITS'(1);
                if (init_ptr_q == INDEX_BITS'(ENTRIES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (resolve_valid) begin
                    if (count_q == '0) begin
                        resolve_error_d = 1'b1;
                    end else begin
                        pht_we    = 1'b1;
                        pht_waddr = head_idx;
                        if (resolve_taken) begin
                            pht_wdata = (head_ctr == 2'b11) ? 2'b11 : head_ctr + 2'b01;
                        end else begin
                            pht_wdata = (head_ctr == 2'b00) ? 2'b00 : head_ctr - 2'b01;
                        end
                        mispredict_d = (resolve_taken != head_pred);
                        // A mispredict makes every younger entry wrong-path: drop them all.
                        if (mispredict_d) begin
                            head_d  = '0;
                            tail_d  = '0;
                            count_d = '0;
                        end else begin
                            head_d  = head_q + PTR_W'(1);
                            count_d = count_q - CNT_W'(1);
                        end
                    end
                end else if (lookup_valid && lookup_ready) begin
                    lookup_fire     = 1'b1;
                    predict_valid_d = 1'b1;
                    predict_d       = pht[lookup_index][1];
                    tail_d          = tail_q + PTR_W'(1);
                    count_d         = count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_ptr_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            predict_valid <= 1'b0;
            predict       <= 1'b0;
            mispredict    <= 1'b0;
            resolve_error <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            init_ptr_q    <= init_ptr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            predict_valid <= predict_valid_d;
            predict       <= predict_d;
            mispredict    <= mispredict_d;
            resolve_error <= resolve_error_d;
            init_done     <= (state_d == ST_RUN);
        end
    end

    // PHT and FIFO storage; contents are rebuilt by INIT so they need no reset.
    always_ff @(posedge clk) begin
        if (!reset && pht_we) begin
            pht[pht_waddr] <= pht_wdata;
        end
        if (!reset && lookup_fire) begin
            fifo_idx[tail_q]  <= lookup_index;
            fifo_pred[tail_q] <= predict_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_controller.sv
// Scoreboard bench for branch_predictor_controller (INDEX_BITS=4, DEPTH=4).
module tb_branch_predictor_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       lookup_valid;
    logic [3:0] lookup_index;
    logic       lookup_ready;
    logic       predict_valid;
    logic       predict;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       mispredict;
    logic       resolve_error;
    logic [2:0] inflight_count;
    logic       init_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic run_phase = 1'b0;
    logic exp_pred_q[$];
    logic [1:0] exp_res_q[$];   // {mispredict, resolve_error}

    always #5 clk = ~clk;

    branch_predictor_controller #(
        .INDEX_BITS(4),
        .DEPTH(4),
        .INIT_STATE(2'b01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lookup_valid(lookup_valid),
        .lookup_index(lookup_index),
        .lookup_ready(lookup_ready),
        .predict_valid(predict_valid),
        .predict(predict),
        .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken),
        .mispredict(mispredict),
        .resolve_error(resolve_error),
        .inflight_count(inflight_count),
        .init_done(init_done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        logic r;
        logic e;
        logic [1:0] er;
        forever begin
            @(posedge clk);
            r = resolve_valid && run_phase && !reset;
            @(negedge clk);
            if (predict_valid) begin
                if (exp_pred_q.size() == 0) begin
                    check("unexpected_predict_valid", 1, 0);
                end else begin
                    e = exp_pred_q.pop_front();
                    check("predict", int'(predict), int'(e));
                end
            end
            if (r) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_resolve", 1, 0);
                end else begin
                    er = exp_res_q.pop_front();
                    check("mispredict", int'(mispredict), int'(er[1]));
                    check("resolve_error", int'(resolve_error), int'(er[0]));
                end
            end else if (mispredict || resolve_error) begin
                check("spurious_resolve_pulse", int'({mispredict, resolve_error}), 0);
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic do_lookup(input logic [3:0] idx, input logic exp);
        int n;
        lookup_valid = 1'b1;
        lookup_index = idx;
        n = 0;
        @(negedge clk);
        while (!lookup_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!lookup_ready) check("lookup_accept_timeout", 0, 1);
        else exp_pred_q.push_back(exp);
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic taken, input logic exp_mis, input logic exp_err);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        exp_res_q.push_back({exp_mis, exp_err});
        @(posedge clk);
        #1;
        resolve_valid = 1'b0;
    endtask

    task automatic check_count(input string name, input int exp);
        @(negedge clk);
        check(name, int'(inflight_count), exp);
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset, then watch init_done rise exactly 16 edges later;
    // lookup and resolve are held during INIT and must be ignored.
    task automatic reset_and_init();
        run_phase = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs_zero",
              int'({predict_valid, predict, mispredict, resolve_error, lookup_ready, init_done}), 0);
        check("rst_inflight_zero", int'(inflight_count), 0);
        lookup_valid  = 1'b1;
        lookup_index  = 4'd3;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 15) begin
                lookup_valid  = 1'b0;
                resolve_valid = 1'b0;
            end
            @(negedge clk);
            if (k == 1 || k >= 15) begin
                check("init_done_timing", int'(init_done), int'(k == 16));
                check("lookup_ready_init", int'(lookup_ready), int'(k == 16));
            end
        end
        @(posedge clk);
        #1;
        run_phase = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        lookup_valid  = 1'b0;
        lookup_index  = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: init timing
        reset_and_init();

        // 2: idx 3 weakly not-taken, taken resolve flips prediction
        do_lookup(4'd3, 1'b0);
        do_resolve(1'b1, 1'b1, 1'b0);          // e3=10
        do_lookup(4'd3, 1'b1);
        do_resolve(1'b1, 1'b0, 1'b0);          // e3=11

        // 3: saturate idx 5 at 11, then one not-taken
        do_lookup(4'd5, 1'b0);
        do_resolve(1'b1, 1'b1, 1'b0);          // 10
        for (int i = 0; i < 3; i++) begin
            do_lookup(4'd5, 1'b1);
            do_resolve(1'b1, 1'b0, 1'b0);      // 11, saturated
        end
        do_lookup(4'd5, 1'b1);
        do_resolve(1'b0, 1'b1, 1'b0);          // 10
        do_lookup(4'd5, 1'b1);
        do_resolve(1'b1, 1'b0, 1'b0);          // 11

        // 4: fill FIFO, refuse extra lookup, then correct and wrong resolves
        do_lookup(4'd8, 1'b0);
        do_lookup(4'd9, 1'b0);
        do_lookup(4'd10, 1'b0);
        do_lookup(4'd11, 1'b0);
        lookup_valid = 1'b1;
        lookup_index = 4'd12;
        @(negedge clk);
        check("full_count", int'(inflight_count), 4);
        check("full_lookup_ready", int'(lookup_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_still_4", int'(inflight_count), 4);
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        do_resolve(1'b0, 1'b0, 1'b0);          // e8=00
        check_count("count_after_correct", 3);
        do_resolve(1'b1, 1'b1, 1'b0);          // e9=10, flush 10/11
        check_count("count_after_flush", 0);
        do_lookup(4'd10, 1'b0);                // flushed entry still 01
        do_resolve(1'b1, 1'b1, 1'b0);          // e10=10
        do_lookup(4'd10, 1'b1);
        do_resolve(1'b0, 1'b1, 1'b0);          // e10=01
        do_lookup(4'd11, 1'b0);                // flushed entry still 01
        do_resolve(1'b0, 1'b0, 1'b0);          // e11=00
        do_lookup(4'd8, 1'b0);
        do_resolve(1'b0, 1'b0, 1'b0);          // e8=00
        do_lookup(4'd9, 1'b1);
        do_resolve(1'b1, 1'b0, 1'b0);          // e9=11

        // 5: resolve with nothing in flight; PHT (e10, a stale head slot) unchanged
        do_resolve(1'b1, 1'b0, 1'b1);
        check_count("count_after_error", 0);
        do_lookup(4'd10, 1'b0);
        do_resolve(1'b0, 1'b0, 1'b0);          // e10=00
        // lookup and resolve together: resolve wins, lookup waits
        do_lookup(4'd4, 1'b0);
        lookup_valid  = 1'b1;
        lookup_index  = 4'd4;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        exp_res_q.push_back(2'b00);            // e4=00
        @(negedge clk);
        check("lookup_ready_vs_resolve", int'(lookup_ready), 0);
        @(posedge clk);
        #1;
        resolve_valid = 1'b0;
        do_lookup(4'd4, 1'b0);
        do_resolve(1'b0, 1'b0, 1'b0);

        // 6: reset mid-INIT (ptr=7), then reset with two in flight
        run_phase = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_and_init();
        do_lookup(4'd1, 1'b0);
        do_lookup(4'd2, 1'b0);
        check_count("two_in_flight", 2);
        reset_and_init();
        check_count("count_after_reset", 0);
        do_lookup(4'd3, 1'b0);                 // e3 back to 01
        do_resolve(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("pred_queue_drained", exp_pred_q.size(), 0);
        check("resolve_queue_drained", exp_res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
